id_ex_stage: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the ALU.
- Registers decoded instruction fields and register-file read data, and decodes ALUOp/funct into the 4-bit alucontrol.
- Resolves operand forwarding and the ALUSrc immediate mux, then drives ALU_operand_1/ALU_operand_2/alucontrol into the ALU.
- Uses a valid/ready handshake upstream and downstream, with flush support.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/id_ex_stage_if.sv | 60 ++++++
 rtl/alu_control_decoder.sv | 29 ++
 rtl/id_ex_stage.sv | 111 +++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, ALUOp encodings, funct codes.
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: upstream handshake, decoded fields, forward sources and ALU-facing outputs.
interface id_ex_stage_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
);
  logic                  id_valid;
  logic                  id_ready;
  logic                  ex_valid;
  logic                  ex_ready;
  logic                  flush;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [WIDTH-1:0]      id_rs_data;
  logic [WIDTH-1:0]      id_rt_data;
  logic [15:0]           id_imm;
  logic [1:0]            id_aluop;
  logic [5:0]            id_funct;
  logic                  id_alusrc;
  logic                  id_regdst;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_memwrite;
  logic                  id_memtoreg;
  logic                  exmem_regwrite;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [WIDTH-1:0]      exmem_result;
  logic                  memwb_regwrite;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [WIDTH-1:0]      memwb_result;
  logic [3:0]            alucontrol;
  logic [WIDTH-1:0]      ALU_operand_1;
  logic [WIDTH-1:0]      ALU_operand_2;
  logic [WIDTH-1:0]      ex_store_data;
  logic [REG_ADDR_W-1:0] ex_write_reg;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_memtoreg;

  modport master (
    output id_valid, ex_ready, flush,
    output id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_aluop, id_funct,
    output id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg,
    output exmem_regwrite, exmem_rd, exmem_result,
    output memwb_regwrite, memwb_rd, memwb_result,
    input  id_ready, ex_valid, alucontrol, ALU_operand_1, ALU_operand_2, ex_store_data,
    input  ex_write_reg, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );

  modport slave (
    input  id_valid, ex_ready, flush,
    input  id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_aluop, id_funct,
    input  id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg,
    input  exmem_regwrite, exmem_rd, exmem_result,
    input  memwb_regwrite, memwb_rd, memwb_result,
    output id_ready, ex_valid, alucontrol, ALU_operand_1, ALU_operand_2, ex_store_data,
    output ex_write_reg, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );
endinterface

// File: rtl/alu_control_decoder.sv
// Combinational ALUOp/funct to 4-bit alucontrol decode.
module alu_control_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_NOP;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_NOP;
        endcase
      end
      default: alucontrol = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: handshake, flush, alucontrol decode, operand muxing.
// Optional macro ID_EX_FORWARDING_EN enables EX/MEM and MEM/WB operand forwarding with hold refresh.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset_n,
  id_ex_stage_if.slave bus
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [WIDTH-1:0]      rs_data_q, rt_data_q, imm_ext_q;
  logic [3:0]            aluctl_q;
  logic                  alusrc_q, regdst_q, regwrite_q, memread_q, memwrite_q, memtoreg_q;

  logic [3:0]            aluctl_d;
  logic [WIDTH-1:0]      fwd_rs, fwd_rt;
  logic                  load;

  alu_control_decoder u_alu_ctl (
    .aluop      (bus.id_aluop),
    .funct      (bus.id_funct),
    .alucontrol (aluctl_d)
  );

  assign bus.id_ready = !valid_q || bus.ex_ready;
  assign load         = bus.id_valid && bus.id_ready;

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is hardwired zero.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == rs_q))
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == rs_q))
      fwd_rs = bus.memwb_result;
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == rt_q))
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == rt_q))
      fwd_rt = bus.memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                        bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result};
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_ext_q  <= '0;
      aluctl_q   <= '0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q    <= 1'b1;
      rs_q       <= bus.id_rs;
      rt_q       <= bus.id_rt;
      rd_q       <= bus.id_rd;
      rs_data_q  <= bus.id_rs_data;
      rt_data_q  <= bus.id_rt_data;
      imm_ext_q  <= {{(WIDTH-16){bus.id_imm[15]}}, bus.id_imm};
      aluctl_q   <= aluctl_d;
      alusrc_q   <= bus.id_alusrc;
      regdst_q   <= bus.id_regdst;
      regwrite_q <= bus.id_regwrite;
      memread_q  <= bus.id_memread;
      memwrite_q <= bus.id_memwrite;
      memtoreg_q <= bus.id_memtoreg;
    end else if (valid_q && !bus.ex_ready) begin
`ifdef ID_EX_FORWARDING_EN
      // Capture forwarded values so a producer retiring during the stall is not lost.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
`endif
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.alucontrol    = aluctl_q;
  assign bus.ALU_operand_1 = fwd_rs;
  assign bus.ALU_operand_2 = alusrc_q ? imm_ext_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_write_reg  = regdst_q ? rd_q : rt_q;
  assign bus.ex_regwrite   = valid_q && regwrite_q;
  assign bus.ex_memread    = valid_q && memread_q;
  assign bus.ex_memwrite   = valid_q && memwrite_q;
  assign bus.ex_memtoreg   = valid_q && memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN when defined.
module tb_id_ex_stage;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  id_ex_stage_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.ex_ready = 0; bus.flush = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_aluop = 0; bus.id_funct = 0;
    bus.id_alusrc = 0; bus.id_regdst = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
    bus.exmem_regwrite = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_regwrite = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    #3;
    vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset ex_valid got %b exp 0", bus.ex_valid); end
    vectors++; if (bus.alucontrol !== 4'b0000) begin miscompares++; $display("FAIL reset alucontrol got %b exp 0000", bus.alucontrol); end
    vectors++; if (bus.ALU_operand_1 !== 32'd0 || bus.ALU_operand_2 !== 32'd0) begin miscompares++; $display("FAIL reset operands got %h/%h exp 0/0", bus.ALU_operand_1, bus.ALU_operand_2); end
    vectors++; if (bus.ex_write_reg !== 5'd0 || bus.ex_regwrite !== 1'b0 || bus.ex_memread !== 1'b0 || bus.ex_memwrite !== 1'b0 || bus.ex_memtoreg !== 1'b0) begin miscompares++; $display("FAIL reset ctrl got wr=%0d rw=%b mr=%b mw=%b mt=%b exp all 0", bus.ex_write_reg, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg); end
    vectors++; if (bus.id_ready !== 1'b1) begin miscompares++; $display("FAIL reset id_ready got %b exp 1", bus.id_ready); end
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  task automatic test_rtype_sub();
    @(negedge clk);
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_aluop = 2'b10; bus.id_funct = 6'b100010;
    bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 3; bus.id_rs_data = 9; bus.id_rt_data = 4;
    bus.id_alusrc = 0; bus.id_regdst = 1; bus.id_regwrite = 1;
    step();
    vectors++; if (bus.alucontrol !== 4'b0110) begin miscompares++; $display("FAIL rtype_sub alucontrol got %b exp 0110", bus.alucontrol); end
    vectors++; if (bus.ALU_operand_1 !== 32'd9 || bus.ALU_operand_2 !== 32'd4) begin miscompares++; $display("FAIL rtype_sub operands got %0d/%0d exp 9/4", bus.ALU_operand_1, bus.ALU_operand_2); end
    vectors++; if (bus.ex_valid !== 1'b1 || bus.ex_regwrite !== 1'b1 || bus.ex_write_reg !== 5'd3) begin miscompares++; $display("FAIL rtype_sub ctrl got v=%b rw=%b wr=%0d exp 1/1/3", bus.ex_valid, bus.ex_regwrite, bus.ex_write_reg); end
  endtask

  task automatic test_imm_add();
    @(negedge clk);
    idle();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_aluop = 2'b00; bus.id_alusrc = 1;
    bus.id_imm = 16'hFFFC; bus.id_rs = 1; bus.id_rt = 4; bus.id_rs_data = 100; bus.id_rt_data = 7;
    bus.id_regdst = 0; bus.id_regwrite = 1; bus.id_memread = 1; bus.id_memtoreg = 1;
    step();
    vectors++; if (bus.ALU_operand_2 !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL imm_add operand_2 got %h exp fffffffc", bus.ALU_operand_2); end
    vectors++; if (bus.ALU_operand_1 !== 32'd100 || bus.alucontrol !== 4'b0010) begin miscompares++; $display("FAIL imm_add op1/ctl got %0d/%b exp 100/0010", bus.ALU_operand_1, bus.alucontrol); end
    vectors++; if (bus.ex_write_reg !== 5'd4 || bus.ex_store_data !== 32'd7 || bus.ex_memread !== 1'b1 || bus.ex_memtoreg !== 1'b1 || bus.ex_memwrite !== 1'b0) begin miscompares++; $display("FAIL imm_add ctrl got wr=%0d sd=%0d mr=%b mt=%b mw=%b exp 4/7/1/1/0", bus.ex_write_reg, bus.ex_store_data, bus.ex_memread, bus.ex_memtoreg, bus.ex_memwrite); end
  endtask

  task automatic test_back_to_back_decode();
    logic [11:0] tbl [8];
    tbl = '{ {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100100, 4'b0000},
             {2'b10, 6'b100101, 4'b0001}, {2'b10, 6'b101010, 4'b0111},
             {2'b10, 6'b000000, 4'b1111}, {2'b01, 6'b100100, 4'b0110},
             {2'b11, 6'b100000, 4'b1111}, {2'b00, 6'b101010, 4'b0010} };
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      bus.id_valid = 1; bus.ex_ready = 1;
      bus.id_aluop = tbl[i][11:10]; bus.id_funct = tbl[i][9:4];
      bus.id_rs_data = 32'(i + 10);
      step();
      vectors++; if (bus.alucontrol !== tbl[i][3:0] || bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL decode[%0d] got ctl=%b v=%b exp ctl=%b v=1", i, bus.alucontrol, bus.ex_valid, tbl[i][3:0]); end
      vectors++; if (bus.ALU_operand_1 !== 32'(i + 10)) begin miscompares++; $display("FAIL b2b[%0d] operand_1 got %0d exp %0d", i, bus.ALU_operand_1, i + 10); end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    @(negedge clk);
    idle();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_rs = 5; bus.id_rt = 6;
    bus.id_rs_data = 11; bus.id_rt_data = 22; bus.id_aluop = 2'b00;
    step();
    bus.id_valid = 0; bus.ex_ready = 0;
    bus.exmem_regwrite = 1; bus.exmem_rd = 5; bus.exmem_result = 77;
    bus.memwb_regwrite = 1; bus.memwb_rd = 5; bus.memwb_result = 55;
    #1;
    exp = FWD ? 32'd77 : 32'd11;
    vectors++; if (bus.ALU_operand_1 !== exp) begin miscompares++; $display("FAIL fwd_exmem_prio operand_1 got %0d exp %0d", bus.ALU_operand_1, exp); end
    bus.exmem_rd = 0; bus.memwb_rd = 0;
    #1;
    vectors++; if (bus.ALU_operand_1 !== 32'd11) begin miscompares++; $display("FAIL fwd_r0 operand_1 got %0d exp 11", bus.ALU_operand_1); end
    bus.memwb_rd = 5;
    #1;
    exp = FWD ? 32'd55 : 32'd11;
    vectors++; if (bus.ALU_operand_1 !== exp) begin miscompares++; $display("FAIL fwd_memwb operand_1 got %0d exp %0d", bus.ALU_operand_1, exp); end
    bus.memwb_rd = 6; bus.memwb_result = 66;
    #1;
    exp = FWD ? 32'd66 : 32'd22;
    vectors++; if (bus.ALU_operand_2 !== exp || bus.ex_store_data !== exp) begin miscompares++; $display("FAIL fwd_rt op2/store got %0d/%0d exp %0d", bus.ALU_operand_2, bus.ex_store_data, exp); end
    idle();
  endtask

  task automatic test_stall_refresh();
    logic [31:0] exp;
    exp = FWD ? 32'd42 : 32'd2;
    @(negedge clk);
    idle();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_rs = 7; bus.id_rt = 8;
    bus.id_rs_data = 1; bus.id_rt_data = 2;
    step();
    @(negedge clk);
    bus.id_valid = 1; bus.id_rs = 9; bus.id_rt = 10; bus.id_rs_data = 99; bus.id_rt_data = 98;
    bus.ex_ready = 0; bus.memwb_regwrite = 1; bus.memwb_rd = 8; bus.memwb_result = 42;
    #1;
    vectors++; if (bus.id_ready !== 1'b0) begin miscompares++; $display("FAIL stall c0 id_ready got %b exp 0", bus.id_ready); end
    step();
    @(negedge clk);
    bus.memwb_regwrite = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    #1;
    vectors++; if (bus.ALU_operand_2 !== exp || bus.id_ready !== 1'b0) begin miscompares++; $display("FAIL stall c1 op2/id_ready got %0d/%b exp %0d/0", bus.ALU_operand_2, bus.id_ready, exp); end
    for (int c = 2; c <= 3; c++) begin
      step();
      vectors++; if (bus.ALU_operand_2 !== exp || bus.id_ready !== 1'b0 || bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL stall c%0d op2/id_ready/v got %0d/%b/%b exp %0d/0/1", c, bus.ALU_operand_2, bus.id_ready, bus.ex_valid, exp); end
    end
    @(negedge clk);
    bus.ex_ready = 1;
    step();
    vectors++; if (bus.ALU_operand_1 !== 32'd99 || bus.ALU_operand_2 !== 32'd98 || bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL stall_release got %0d/%0d v=%b exp 99/98 v=1", bus.ALU_operand_1, bus.ALU_operand_2, bus.ex_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    bus.flush = 1; bus.id_valid = 1; bus.ex_ready = 1; bus.id_regwrite = 1; bus.id_rs_data = 5;
    step();
    vectors++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.id_ready !== 1'b1) begin miscompares++; $display("FAIL flush got v=%b rw=%b rdy=%b exp 0/0/1", bus.ex_valid, bus.ex_regwrite, bus.id_ready); end
    @(negedge clk);
    idle();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_aluop = 2'b01; bus.id_rs_data = 50; bus.id_rt_data = 8;
    bus.id_rt = 3; bus.id_regwrite = 1;
    step();
    vectors++; if (bus.ex_valid !== 1'b1 || bus.alucontrol !== 4'b0110 || bus.ALU_operand_1 !== 32'd50 || bus.ALU_operand_2 !== 32'd8) begin miscompares++; $display("FAIL post_flush got v=%b ctl=%b %0d/%0d exp 1/0110 50/8", bus.ex_valid, bus.alucontrol, bus.ALU_operand_1, bus.ALU_operand_2); end
    vectors++; if (bus.ex_regwrite !== 1'b1 || bus.ex_write_reg !== 5'd3) begin miscompares++; $display("FAIL post_flush ctrl got rw=%b wr=%0d exp 1/3", bus.ex_regwrite, bus.ex_write_reg); end
    @(negedge clk);
    idle();
    bus.flush = 1; bus.ex_ready = 0;
    step();
    vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stalled ex_valid got %b exp 0", bus.ex_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_aluop = 2'b10; bus.id_funct = 6'b100101;
    bus.id_rs_data = 123; bus.id_rt_data = 45; bus.id_regwrite = 1;
    step();
    @(negedge clk);
    bus.id_valid = 0; bus.ex_ready = 0;
    step();
    vectors++; if (bus.id_ready !== 1'b0 || bus.alucontrol !== 4'b0001) begin miscompares++; $display("FAIL pre_reset stall got rdy=%b ctl=%b exp 0/0001", bus.id_ready, bus.alucontrol); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.alucontrol !== 4'b0000) begin miscompares++; $display("FAIL mid_reset got v=%b rw=%b ctl=%b exp 0/0/0000", bus.ex_valid, bus.ex_regwrite, bus.alucontrol); end
    vectors++; if (bus.ALU_operand_1 !== 32'd0 || bus.ALU_operand_2 !== 32'd0 || bus.id_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset ops got %0d/%0d rdy=%b exp 0/0/1", bus.ALU_operand_1, bus.ALU_operand_2, bus.id_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    vectors++; if (bus.ex_valid !== 1'b0 || bus.id_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset got v=%b rdy=%b exp 0/1", bus.ex_valid, bus.id_ready); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_rtype_sub();
    test_imm_add();
    test_back_to_back_decode();
    test_forwarding();
    test_stall_refresh();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
